// File: rtl/uart_core_cfg.sv
// Full-duplex UART with configurable data bits, parity and stop bits.
// TX and a 16x-oversampled RX share one free-running baud-tick divider.
module uart_core_cfg #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DATA_BITS-1:0] dintx,
  input  logic                 newd,
  output logic                 tx,
  output logic [DATA_BITS-1:0] doutrx,
  output logic                 donetx,
  output logic                 donerx,
  output logic                 txbusy,
  output logic                 rxbusy,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;

  assign tick = (div_cnt_reg == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_cnt_reg <= '0;
    else      div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  tx_state_t            tx_state_reg, tx_state_next;
  logic [3:0]           tx_tick_reg, tx_tick_next;
  logic [BIT_W-1:0]     tx_bit_reg, tx_bit_next;
  logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic                 tx_par_reg, tx_par_next;
  logic                 tx_reg, tx_next;
  logic                 donetx_reg, donetx_next;
  logic                 tx_bit_end;

  // Each bit ends on the 16th tick; the 4-bit counter wraps by itself.
  assign tx_bit_end = tick && (tx_tick_reg == 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_reg <= TX_IDLE;
      tx_tick_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      donetx_reg   <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_tick_reg  <= tx_tick_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_par_reg   <= tx_par_next;
      tx_reg       <= tx_next;
      donetx_reg   <= donetx_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_tick_next  = tick ? tx_tick_reg + 4'd1 : tx_tick_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_par_next   = tx_par_reg;
    donetx_next   = 1'b0;
    tx_next       = 1'b1;

    case (tx_state_reg)
      TX_IDLE: begin
        tx_tick_next = '0;
        // The done cycle still counts as busy, so a held newd waits one cycle.
        if (newd && !donetx_reg) begin
          tx_shift_next = dintx;
          tx_par_next   = (PARITY == 1) ? ~(^dintx) : ^dintx;
          tx_bit_next   = '0;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_bit_next   = '0;
          tx_state_next = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_next = tx_shift_reg >> 1;
          if (tx_bit_reg == BIT_W'(DATA_BITS - 1)) begin
            tx_bit_next   = '0;
            tx_state_next = (PARITY != 0) ? TX_PAR : TX_STOP;
          end else begin
            tx_bit_next = tx_bit_reg + 1'b1;
          end
        end
      end
      TX_PAR: begin
        if (tx_bit_end) begin
          tx_bit_next   = '0;
          tx_state_next = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_bit_reg == BIT_W'(STOP_BITS - 1)) begin
            tx_state_next = TX_IDLE;
            donetx_next   = 1'b1;
          end else begin
            tx_bit_next = tx_bit_reg + 1'b1;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase

    case (tx_state_next)
      TX_START: tx_next = 1'b0;
      TX_DATA:  tx_next = tx_shift_next[0];
      TX_PAR:   tx_next = tx_par_next;
      default:  tx_next = 1'b1;
    endcase
  end

  assign tx     = tx_reg;
  assign donetx = donetx_reg;
  assign txbusy = (tx_state_reg != TX_IDLE) || donetx_reg;

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HI} rx_state_t;

  logic [1:0]           sync_reg;
  logic                 rx_s;
  rx_state_t            rx_state_reg, rx_state_next;
  logic [3:0]           rx_tick_reg, rx_tick_next;
  logic [BIT_W-1:0]     rx_bit_reg, rx_bit_next;
  logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic                 rx_par_bad_reg, rx_par_bad_next;
  logic [DATA_BITS-1:0] doutrx_reg, doutrx_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 donerx_reg, donerx_next;
  logic                 rx_sample;
  logic                 rx_par_exp;

  assign rx_s       = sync_reg[1];
  assign rx_sample  = tick && (rx_tick_reg == 4'd15);
  assign rx_par_exp = (PARITY == 1) ? ~(^rx_shift_reg) : ^rx_shift_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg       <= 2'b11;
      rx_state_reg   <= RX_IDLE;
      rx_tick_reg    <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_par_bad_reg <= 1'b0;
      doutrx_reg     <= '0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      donerx_reg     <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[0], rx};
      rx_state_reg   <= rx_state_next;
      rx_tick_reg    <= rx_tick_next;
      rx_bit_reg     <= rx_bit_next;
      rx_shift_reg   <= rx_shift_next;
      rx_par_bad_reg <= rx_par_bad_next;
      doutrx_reg     <= doutrx_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
      donerx_reg     <= donerx_next;
    end
  end

  always_comb begin
    rx_state_next   = rx_state_reg;
    rx_tick_next    = tick ? rx_tick_reg + 4'd1 : rx_tick_reg;
    rx_bit_next     = rx_bit_reg;
    rx_shift_next   = rx_shift_reg;
    rx_par_bad_next = rx_par_bad_reg;
    doutrx_next     = doutrx_reg;
    parity_err_next = parity_err_reg;
    frame_err_next  = frame_err_reg;
    donerx_next     = 1'b0;

    case (rx_state_reg)
      RX_IDLE: begin
        rx_tick_next = '0;
        if (!rx_s) rx_state_next = RX_START;
      end
      RX_START: begin
        // Mid-start check; restarting the count here centres all later samples.
        if (tick && (rx_tick_reg == 4'd7)) begin
          rx_tick_next  = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_next = {rx_s, rx_shift_reg[DATA_BITS-1:1]};
          if (rx_bit_reg == BIT_W'(DATA_BITS - 1)) begin
            rx_bit_next   = '0;
            rx_state_next = (PARITY != 0) ? RX_PAR : RX_STOP;
          end else begin
            rx_bit_next = rx_bit_reg + 1'b1;
          end
        end
      end
      RX_PAR: begin
        if (rx_sample) begin
          rx_par_bad_next = (rx_s != rx_par_exp);
          rx_state_next   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          doutrx_next     = rx_shift_reg;
          parity_err_next = (PARITY != 0) && rx_par_bad_reg;
          frame_err_next  = !rx_s;
          donerx_next     = 1'b1;
          // A low stop bit may be a break; wait for the line to recover.
          rx_state_next   = rx_s ? RX_IDLE : RX_WAIT_HI;
        end
      end
      RX_WAIT_HI: begin
        if (rx_s) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  assign doutrx     = doutrx_reg;
  assign donerx     = donerx_reg;
  assign rxbusy     = (rx_state_reg != RX_IDLE);
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;

endmodule
